// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial frame transmitter and its detector bench.
// SEQ_FRAME_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package seq_pkg;

    localparam int unsigned DefaultWidth     = 8;
    localparam int unsigned DefaultGapCycles = 4;
    localparam logic        IdleLevel        = 1'b0;

`ifdef SEQ_FRAME_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity, StGap} seq_state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StGap} seq_state_e;
`endif

endpackage

// File: rtl/seq_frame_tx_if.sv
// Word-in / bit-stream-out bundle of seq_frame_tx.
// master = word producer and stream consumer, slave = the transmitter.
interface seq_frame_tx_if #(
    parameter int unsigned WIDTH = seq_pkg::DefaultWidth
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             seq;
    logic             seq_valid;
    logic             frame_start;
    logic             done;
    logic             busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, seq, seq_valid, frame_start, done, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, seq, seq_valid, frame_start, done, busy
    );
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter with terminal-count flag; saturates at zero rather than wrapping.
module seq_down_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);
    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);
endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: shifts a handshaken word out on seq, then idles for a fixed gap.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the data bits.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned GAP_CYCLES = DefaultGapCycles,
    parameter logic        IDLE_LEVEL = IdleLevel,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    seq_frame_tx_if.slave  bus
);
    localparam int unsigned BitCntW = $clog2(WIDTH);
    localparam logic [BitCntW-1:0] BitLoad = BitCntW'(WIDTH - 1);
    localparam logic [7:0] GapLoad = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             seq_q, seq_d;
    logic             seq_valid_q, seq_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic accept;
    logic bit_load, bit_en, bit_tc;
    logic gap_load, gap_en, gap_tc;

    function automatic logic out_bit(logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign bus.data_ready = (state_q == StIdle) && !reset;
    assign accept         = bus.data_valid && bus.data_ready;

    seq_down_counter #(
        .Width (BitCntW)
    ) u_bit_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bit_load),
        .load_val_i (BitLoad),
        .en_i       (bit_en),
        .tc_o       (bit_tc)
    );

    seq_down_counter #(
        .Width (8)
    ) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (GapLoad),
        .en_i       (gap_en),
        .tc_o       (gap_tc)
    );

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        seq_d         = IDLE_LEVEL;
        seq_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        bit_load      = 1'b0;
        bit_en        = 1'b0;
        gap_load      = 1'b0;
        gap_en        = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
        parity_d      = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d       = StShift;
                    seq_d         = out_bit(bus.data_in);
                    shift_d       = shift_word(bus.data_in);
                    seq_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    bit_load      = 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
                    parity_d      = ^bus.data_in;
`endif
                end
            end
            StShift: begin
                if (!bit_tc) begin
                    bit_en      = 1'b1;
                    seq_d       = out_bit(shift_q);
                    shift_d     = shift_word(shift_q);
                    seq_valid_d = 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
                end else begin
                    state_d     = StParity;
                    seq_d       = parity_q;
                    seq_valid_d = 1'b1;
                end
            end
            StParity: begin
                begin
`else
                end else begin
`endif
                    if (GAP_CYCLES == 0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StGap;
                        gap_load = 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_tc) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    gap_en = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            seq_q         <= IDLE_LEVEL;
            seq_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            seq_q         <= seq_d;
            seq_valid_q   <= seq_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign bus.seq         = seq_q;
    assign bus.seq_valid   = seq_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx with default parameters; a per-cycle vector table plus a
// hand-written back-to-back period measurement. Honours SEQ_FRAME_TX_PARITY_EN.
module tb_seq_frame_tx;

    localparam int W   = 8;
    localparam int GAP = 4;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int PERIOD = W + GAP + 1 + PAR;

    // Expected output bundle order: {seq, seq_valid, frame_start, done, data_ready, busy}
    localparam logic [5:0] E_IDLE = 6'b000010;
    localparam logic [5:0] E_DONE = 6'b000110;
    localparam logic [5:0] E_GAP  = 6'b000001;
    localparam logic [5:0] E_RST  = 6'b000000;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic [5:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    vec_t vecs[$];
    int   passed;
    int   total;

    seq_frame_tx_if #(.WIDTH(W)) bus ();

    seq_frame_tx #(
        .WIDTH      (W),
        .GAP_CYCLES (GAP),
        .IDLE_LEVEL (1'b0),
        .MSB_FIRST  (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic v, input logic [7:0] d, input logic [5:0] e);
        vec_t t;
        t.rst   = r;
        t.valid = v;
        t.data  = d;
        t.exp   = e;
        vecs.push_back(t);
    endtask

    // Cycles 1..end-of-gap after an acceptance; the done cycle is pushed by the caller.
    task automatic add_frame(input logic [7:0] bits, input logic par, input int ign_cyc,
                             input logic hold_v, input logic [7:0] hold_d);
        logic       v;
        logic [7:0] d;
        for (int c = 1; c <= W + PAR + GAP; c++) begin
            v = hold_v || (c == ign_cyc);
            d = (c == ign_cyc) ? 8'hFF : hold_d;
            if (c <= W) begin
                push(1'b0, v, d, {bits[W-c], 1'b1, (c == 1), 3'b001});
            end else if (c <= W + PAR) begin
                push(1'b0, v, d, {par, 5'b10001});
            end else begin
                push(1'b0, v, d, E_GAP);
            end
        end
    endtask

    initial begin
        int n;
        int m;
        logic [5:0] act;
        passed         = 0;
        total          = 0;
        reset          = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;

        // Reset for three cycles, then the first released cycle
        for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 8'h00, E_RST);
        push(1'b0, 1'b0, 8'h00, E_IDLE);

        // Single B2 frame
        push(1'b0, 1'b1, 8'hB2, E_IDLE);
        add_frame(8'b10110010, 1'b0, 0, 1'b0, 8'h00);
        push(1'b0, 1'b0, 8'h00, E_DONE);
        push(1'b0, 1'b0, 8'h00, E_IDLE);

        // Back-to-back with valid held; data switches to 3C mid-frame
        push(1'b0, 1'b1, 8'hA5, E_IDLE);
        add_frame(8'b10100101, 1'b0, 0, 1'b1, 8'h3C);
        push(1'b0, 1'b1, 8'h3C, E_DONE);
        add_frame(8'b00111100, 1'b0, 0, 1'b0, 8'h00);
        push(1'b0, 1'b0, 8'h00, E_DONE);

        // FF offered during bit 3 of an all-zero frame is ignored
        push(1'b0, 1'b1, 8'h00, E_IDLE);
        add_frame(8'b00000000, 1'b0, 3, 1'b0, 8'h00);
        push(1'b0, 1'b0, 8'h00, E_DONE);

        // Reset during bit 4 of FF aborts without done
        push(1'b0, 1'b1, 8'hFF, E_IDLE);
        push(1'b0, 1'b0, 8'h00, 6'b111001);
        push(1'b0, 1'b0, 8'h00, 6'b110001);
        push(1'b0, 1'b0, 8'h00, 6'b110001);
        push(1'b1, 1'b0, 8'h00, 6'b110001);
        push(1'b0, 1'b0, 8'h00, E_IDLE);
        for (int i = 0; i < 14; i++) push(1'b0, 1'b0, 8'h00, E_IDLE);
        push(1'b0, 1'b1, 8'h81, E_IDLE);
        add_frame(8'b10000001, 1'b0, 0, 1'b0, 8'h00);
        push(1'b0, 1'b0, 8'h00, E_DONE);

        // Odd-weight word: parity bit 1 when the feature is built in
        push(1'b0, 1'b1, 8'h07, E_IDLE);
        add_frame(8'b00000111, 1'b1, 0, 1'b0, 8'h00);
        push(1'b0, 1'b0, 8'h00, E_DONE);
        push(1'b0, 1'b0, 8'h00, E_IDLE);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            bus.data_valid = vecs[i].valid;
            bus.data_in    = vecs[i].data;
            #1;
            act = {bus.seq, bus.seq_valid, bus.frame_start, bus.done, bus.data_ready, bus.busy};
            check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
        end

        // Hand sequence: with valid held, measure frame_start to frame_start spacing
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h5A;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 40);
        check("first_start_latency", 32'(n), 32'd1);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!bus.frame_start && m < 40);
        check("accept_period", 32'(m), 32'(PERIOD));
        bus.data_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 40);
        check("final_done_latency", 32'(n), 32'(PERIOD - 1));
        @(negedge clk);
        check("idle_after_done", 32'({bus.busy, bus.data_ready, bus.seq}), 32'b010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
